// File: rtl/prio_encoder8x3.sv
// Registered 8-to-3 priority encoder.
// Request lines are latched into a pending vector. Pending indices are presented
// highest-first on a valid/ready handshake. Each pending bit is cleared when its
// code is accepted.
module prio_encoder8x3 #(
    parameter int N_IN  = 8,
    parameter int OUT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   req_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_code,
    output logic [N_IN-1:0]   pending_o,
    output logic              req_lost
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [N_IN-1:0]    pending, pending_nxt;
    logic [N_IN-1:0]    clr;
    logic [N_IN-1:0]    rem;
    logic               accept;
    logic               valid_nxt;
    logic [OUT_W-1:0]   code_nxt;
    logic               lost_nxt;

    // Index of the highest set bit; the last match in an ascending scan wins.
    function automatic logic [OUT_W-1:0] hi_idx(input logic [N_IN-1:0] v);
        hi_idx = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (v[i]) hi_idx = OUT_W'(i);
        end
    endfunction

    // Handshake decode, pending update, and next-state/next-output selection.
    always_comb begin
        accept      = out_valid & out_ready;
        clr         = accept ? (N_IN'(1) << out_code) : '0;
        rem         = pending & ~clr;
        pending_nxt = rem | req_in;
        lost_nxt    = |(req_in & rem);
        state_nxt   = state;
        valid_nxt   = out_valid;
        code_nxt    = out_code;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (pending != '0) begin
                    code_nxt  = hi_idx(pending);
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                valid_nxt = 1'b1;
                // The reload uses only registered pending, so this cycle's req_in is not eligible yet.
                if (accept) begin
                    if (rem != '0) begin
                        code_nxt = hi_idx(rem);
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pending vector and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            req_lost  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out_valid <= valid_nxt;
            out_code  <= code_nxt;
            req_lost  <= lost_nxt;
        end
    end

    assign pending_o = pending;

endmodule

// File: tb/tb_prio_encoder8x3.sv
// Directed testbench for prio_encoder8x3.
// Inputs are driven and outputs are checked 1 ns after each rising edge.
module tb_prio_encoder8x3;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] pending_o;
    logic       req_lost;

    int unsigned n_cmp;
    int unsigned n_fail;
    logic [7:0]  acc;

    prio_encoder8x3 #(.N_IN(8), .OUT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pending_o (pending_o),
        .req_lost  (req_lost)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks valid, code, pending vector and lost flag in one call.
    task automatic chk_all(input string tag, input logic v, input logic [2:0] c,
                           input logic [7:0] p, input logic l);
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
        chk({tag, ".code"}, {5'd0, out_code}, {5'd0, c});
        chk({tag, ".pend"}, pending_o, p);
        chk({tag, ".lost"}, {7'd0, req_lost}, {7'd0, l});
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; acc = '0;
        rst_n = 1'b0; req_in = '0; out_ready = 1'b0;
        tick(); tick();
        chk_all("rst0", 1'b0, 3'd0, 8'h00, 1'b0);
        rst_n = 1'b1;

        // Reset asserted mid-HOLD with pending 8'hA5
        req_in = 8'hA5; tick(); req_in = '0;
        chk_all("rstA.latch", 1'b0, 3'd0, 8'hA5, 1'b0);
        tick();
        chk_all("rstA.hold", 1'b1, 3'd7, 8'hA5, 1'b0);
        rst_n = 1'b0; #1;
        chk_all("rstA.async", 1'b0, 3'd0, 8'h00, 1'b0);
        tick(); rst_n = 1'b1;
        tick(); tick(); tick();
        chk_all("rstA.idle", 1'b0, 3'd0, 8'h00, 1'b0);

        // Single 1-cycle request 8'h08 with ready held high
        out_ready = 1'b1;
        req_in = 8'h08; tick(); req_in = '0;
        chk_all("single.e0", 1'b0, 3'd0, 8'h08, 1'b0);
        tick();
        chk_all("single.e1", 1'b1, 3'd3, 8'h08, 1'b0);
        tick();
        chk("single.done.valid", {7'd0, out_valid}, 8'h00);
        chk("single.done.pend", pending_o, 8'h00);

        // Multi-bit request 8'h91 presented 7, 4, 0 back to back
        req_in = 8'h91; tick(); req_in = '0;
        chk("prio.latch", pending_o, 8'h91);
        tick();
        chk_all("prio.c7", 1'b1, 3'd7, 8'h91, 1'b0);
        acc = acc | (8'd1 << out_code);
        tick();
        chk_all("prio.c4", 1'b1, 3'd4, 8'h11, 1'b0);
        acc = acc | (8'd1 << out_code);
        tick();
        chk_all("prio.c0", 1'b1, 3'd0, 8'h01, 1'b0);
        acc = acc | (8'd1 << out_code);
        tick();
        chk("prio.end.valid", {7'd0, out_valid}, 8'h00);
        chk("prio.end.pend", pending_o, 8'h00);
        chk("prio.decoded_or", acc, 8'h91);

        // Backpressure with no preemption
        out_ready = 1'b0;
        req_in = 8'h04; tick(); req_in = '0;
        tick();
        chk_all("bp.c2", 1'b1, 3'd2, 8'h04, 1'b0);
        req_in = 8'h80; tick(); req_in = '0;
        chk_all("bp.nopreempt", 1'b1, 3'd2, 8'h84, 1'b0);
        tick();
        chk_all("bp.frozen", 1'b1, 3'd2, 8'h84, 1'b0);
        out_ready = 1'b1; tick();
        chk_all("bp.c7", 1'b1, 3'd7, 8'h80, 1'b0);
        tick();
        chk_all("bp.end", 1'b0, 3'd7, 8'h00, 1'b0);

        // Same-cycle set and clear of bit 5
        out_ready = 1'b0;
        req_in = 8'h20; tick(); req_in = '0;
        tick();
        chk_all("sc.c5", 1'b1, 3'd5, 8'h20, 1'b0);
        out_ready = 1'b1; req_in = 8'h20; tick(); req_in = '0;
        chk_all("sc.setwins", 1'b0, 3'd5, 8'h20, 1'b0);
        tick();
        chk_all("sc.again", 1'b1, 3'd5, 8'h20, 1'b0);
        tick();
        chk_all("sc.end", 1'b0, 3'd5, 8'h00, 1'b0);

        // Lost request on an already pending bit
        out_ready = 1'b0;
        req_in = 8'h02; tick(); req_in = '0;
        tick();
        chk_all("lost.c1", 1'b1, 3'd1, 8'h02, 1'b0);
        req_in = 8'h02; tick(); req_in = '0;
        chk_all("lost.pulse", 1'b1, 3'd1, 8'h02, 1'b1);
        tick();
        chk_all("lost.once", 1'b1, 3'd1, 8'h02, 1'b0);
        out_ready = 1'b1; tick();
        chk_all("lost.accept", 1'b0, 3'd1, 8'h00, 1'b0);
        tick(); tick();
        chk_all("lost.nodup", 1'b0, 3'd1, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
